adc_serial_rx: RTL and testbench

Serial receive stage directly downstream of the ADC SCLK generator. It consumes the divided SCLK (free-running, synchronous to clk_clk) and frames conversions by driving the ADC chip-select. It shifts in the ADC's serial data on SCLK rising edges and presents each completed sample to the audio datapath through a valid/ready handshake. It targets 16-clock-frame SAR ADCs: 4 leading zero bits followed by 12 data bits, MSB first.

---
 rtl/adc_pkg.sv | 17 +
 rtl/sclk_edge_det.sv | 23 ++
 rtl/adc_serial_rx.sv | 156 +++++++++++++++
 tb/tb_adc_serial_rx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC serial receive path (and the matching DAC
// transmit stage): frame geometry defaults and the receive FSM state type.
package adc_pkg;

  localparam int ADC_DATA_W     = 12;
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_LEAD_BITS  = 4;
  localparam int ADC_QUIET_SCLK = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } adc_rx_state_e;

endpackage

// File: rtl/sclk_edge_det.sv
// SCLK edge detector: SCLK is generated from the system clock, so a single
// delay register is enough to find its edges. rise/fall are valid in the
// cycle in which the new SCLK level is first seen.
module sclk_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  output logic o_rise,
  output logic o_fall
);

  logic r_sclk_d;

  // one-cycle delayed copy of SCLK
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_sclk_d <= 1'b0;
    else          r_sclk_d <= i_sclk;
  end

  assign o_rise = i_sclk & ~r_sclk_d;
  assign o_fall = ~i_sclk & r_sclk_d;

endmodule

// File: rtl/adc_serial_rx.sv
// ADC serial receive stage. Frames conversions with ADC_CS_N, shifts in
// ADC_DOUT on SCLK rising edges and hands each sample to the audio datapath
// over a valid/ready handshake (a new sample overwrites an unconsumed one
// and pulses overrun).
// Build option: define ADC_TWOS_COMP_EN to invert the sample MSB at load
// (offset binary -> two's complement); undefined gives the raw ADC code.
//
// state | meaning
// IDLE  | CS_N high, waiting for an SCLK fall with enable set
// ARM   | CS_N low, waiting for the first rise (bit 0)
// SHIFT | CS_N low, shifting bits 1..FRAME_BITS-1
// QUIET | CS_N high, counting quiet SCLK falls before the next frame
module adc_serial_rx
  import adc_pkg::*;
#(
  parameter int DATA_W     = ADC_DATA_W,
  parameter int FRAME_BITS = ADC_FRAME_BITS,
  parameter int LEAD_BITS  = ADC_LEAD_BITS,
  parameter int QUIET_SCLK = ADC_QUIET_SCLK
) (
  input  logic              clk_clk,
  input  logic              reset_n,
  input  logic              SCLK,
  input  logic              enable,
  input  logic              ADC_DOUT,
  output logic              ADC_CS_N,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun
);

  localparam int BITCNT_W = $clog2(FRAME_BITS);
  localparam int QCNT_W   = $clog2(QUIET_SCLK + 1);
  // bits that survive the shift; the leading bits fall off the top
  localparam int KEEP_BITS = FRAME_BITS - LEAD_BITS;
  localparam logic [BITCNT_W-1:0] LAST_BIT   = BITCNT_W'(FRAME_BITS - 1);
  localparam logic [QCNT_W-1:0]   QUIET_LAST = QCNT_W'(QUIET_SCLK);

  adc_rx_state_e r_state, w_state_nxt;

  logic                  w_rise, w_fall;
  logic                  w_shift, w_load, w_qcnt_inc;
  logic [DATA_W-1:0]     w_load_data;
  logic                  r_dout_q;
  logic [KEEP_BITS-2:0]  r_shreg;
  logic [BITCNT_W-1:0]   r_bitcnt;
  logic [QCNT_W-1:0]     r_qcnt;
  logic                  r_cs_n;
  logic [DATA_W-1:0]     r_sample;
  logic                  r_valid;
  logic                  r_overrun;

  sclk_edge_det u_edge (
    .i_clk   (clk_clk),
    .i_rst_n (reset_n),
    .i_sclk  (SCLK),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // state register
  always_ff @(posedge clk_clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_qcnt_inc  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && w_fall) w_state_nxt = ARM;
      end
      ARM: begin
        if (w_rise) begin
          w_shift     = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_rise) begin
          w_shift = 1'b1;
          if (r_bitcnt == LAST_BIT) begin
            w_load      = 1'b1;
            w_state_nxt = QUIET;
          end
        end
      end
      QUIET: begin
        // The first fall after CS_N rises still closes the last data bit's
        // period, so QUIET_SCLK further falls are needed before leaving.
        if (w_fall) begin
          if (r_qcnt == QUIET_LAST) w_state_nxt = IDLE;
          else                      w_qcnt_inc  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // completed sample, optionally converted to two's complement
  always_comb begin
    w_load_data = DATA_W'({r_shreg, r_dout_q});
`ifdef ADC_TWOS_COMP_EN
    w_load_data[DATA_W-1] = ~w_load_data[DATA_W-1];
`endif
  end

  // input register, shift register, bit and quiet counters, chip select
  always_ff @(posedge clk_clk) begin
    if (!reset_n) begin
      r_dout_q <= 1'b0;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_qcnt   <= '0;
      r_cs_n   <= 1'b1;
    end else begin
      r_dout_q <= ADC_DOUT;
      if (w_shift) begin
        r_shreg  <= {r_shreg[KEEP_BITS-3:0], r_dout_q};
        r_bitcnt <= w_load ? '0 : r_bitcnt + 1'b1;
      end
      if (w_load)          r_qcnt <= '0;
      else if (w_qcnt_inc) r_qcnt <= r_qcnt + 1'b1;
      r_cs_n <= !(w_state_nxt == ARM || w_state_nxt == SHIFT);
    end
  end

  // output handshake: a load always wins over a simultaneous accept
  always_ff @(posedge clk_clk) begin
    if (!reset_n) begin
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_load) begin
        r_sample  <= w_load_data;
        r_valid   <= 1'b1;
        r_overrun <= r_valid & ~sample_ready;
      end else if (r_valid && sample_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ADC_CS_N     = r_cs_n;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: free-running SCLK source and a behavioural ADC
// that drives a 16-bit word MSB first while CS_N is low, a sample-level
// model of the handshake, a per-cycle compare and directed literal checks.
module tb_adc_serial_rx;

  localparam int HALF = 12;

`ifdef ADC_TWOS_COMP_EN
  localparam logic [11:0] L_A5C = 12'h25C;
  localparam logic [11:0] L_123 = 12'h923;
  localparam logic [11:0] L_456 = 12'hC56;
  localparam logic [11:0] L_789 = 12'hF89;
  localparam logic [11:0] L_BCD = 12'h3CD;
  localparam logic [11:0] L_E71 = 12'h671;
  localparam logic [11:0] L_321 = 12'hB21;
`else
  localparam logic [11:0] L_A5C = 12'hA5C;
  localparam logic [11:0] L_123 = 12'h123;
  localparam logic [11:0] L_456 = 12'h456;
  localparam logic [11:0] L_789 = 12'h789;
  localparam logic [11:0] L_BCD = 12'hBCD;
  localparam logic [11:0] L_E71 = 12'hE71;
  localparam logic [11:0] L_321 = 12'h321;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SCLK = 1'b0;
  logic        enable = 1'b0;
  logic        ADC_DOUT = 1'b0;
  logic        ADC_CS_N;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int ovr_seen = 0;

  adc_serial_rx dut (
    .clk_clk      (clk_clk),
    .reset_n      (reset_n),
    .SCLK         (SCLK),
    .enable       (enable),
    .ADC_DOUT     (ADC_DOUT),
    .ADC_CS_N     (ADC_CS_N),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  always #5 clk_clk = ~clk_clk;

  function automatic logic [11:0] exp_code(input logic [15:0] w);
`ifdef ADC_TWOS_COMP_EN
    return {~w[11], w[10:0]};
`else
    return w[11:0];
`endif
  endfunction

  // SCLK source and ADC: new bit on each SCLK fall while selected
  int          ph = 0;
  int          adc_cnt = 0;
  logic [15:0] next_word = 16'h0000;
  logic [15:0] cur_word = 16'h0000;
  logic        cs_prev = 1'b1;
  int          adc_done = 0;
  logic [11:0] done_val = 12'h000;
  logic [3:0]  bit_idx;

  always @(negedge clk_clk) begin
    if (ADC_CS_N) adc_cnt = 0;
    else if (cs_prev) cur_word = next_word;
    cs_prev = ADC_CS_N;
    if (ph == HALF - 1) begin
      ph = 0;
      SCLK = ~SCLK;
      if (SCLK && !ADC_CS_N) begin
        adc_cnt++;
        if (adc_cnt == 16) begin
          done_val = exp_code(cur_word);
          adc_done++;
        end
      end
    end else begin
      ph++;
    end
    if (ADC_CS_N) ADC_DOUT = 1'b0;
    else if (!SCLK && adc_cnt < 16) begin
      bit_idx  = 4'(15 - adc_cnt);
      ADC_DOUT = cur_word[bit_idx];
    end
  end

  // sample-level model: a completed frame becomes the presented sample on
  // the next clock; accept clears; overwrite while unconsumed flags overrun
  logic        exp_valid = 1'b0;
  logic        exp_ovr = 1'b0;
  logic [11:0] exp_sample = 12'h000;
  logic        model_live = 1'b0;
  int          model_taken = 0;
  int          loads = 0;

  always @(posedge clk_clk) begin
    model_live = 1'b1;
    if (!reset_n) begin
      exp_valid   = 1'b0;
      exp_ovr     = 1'b0;
      exp_sample  = 12'h000;
      model_taken = adc_done;
    end else if (adc_done != model_taken) begin
      model_taken = adc_done;
      exp_ovr     = exp_valid & ~sample_ready;
      exp_valid   = 1'b1;
      exp_sample  = done_val;
      loads++;
    end else begin
      exp_ovr = 1'b0;
      if (exp_valid && sample_ready) exp_valid = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tfail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  task automatic wait_load(input string name);
    int target;
    int n;
    target = loads + 1;
    n = 0;
    while (loads < target && n < 1000) begin
      @(posedge clk_clk); #1;
      n++;
    end
    if (loads < target) tfail(name);
  endtask

  task automatic wait_bit(input int idx, input bit at_edge, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1200 && !ok; i++) begin
      @(posedge clk_clk); #1;
      if (!ADC_CS_N && adc_cnt == idx && (!at_edge || (!SCLK && ph == HALF - 1)))
        ok = 1'b1;
    end
    if (!ok) tfail(name);
  endtask

  initial begin
    logic prev_s;
    logic prev_cs;
    bit   seen;
    bit   ok;
    int   ovr0;
    int   cs_low;

    fork
      forever begin
        @(negedge clk_clk);
        if (model_live) begin
          check("cyc_valid", 32'(sample_valid), 32'(exp_valid));
          check("cyc_sample", 32'(sample), 32'(exp_sample));
          check("cyc_overrun", 32'(overrun), 32'(exp_ovr));
          if (overrun) ovr_seen++;
        end
      end
    join_none

    // reset, then first frame
    reset_n      = 1'b0;
    enable       = 1'b1;
    sample_ready = 1'b1;
    next_word    = 16'h0A5C;
    repeat (5) begin
      @(posedge clk_clk); #1;
      check("rst_cs_n", 32'(ADC_CS_N), 32'd1);
      check("rst_valid", 32'(sample_valid), 32'd0);
      check("rst_sample", 32'(sample), 32'd0);
    end
    reset_n = 1'b1;

    prev_s  = SCLK;
    prev_cs = ADC_CS_N;
    seen    = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk_clk); #1;
      if (prev_s && !SCLK) begin
        seen = 1'b1;
        check("cs_before_fall", 32'(prev_cs), 32'd1);
        check("cs_after_fall", 32'(ADC_CS_N), 32'd0);
      end
      prev_s  = SCLK;
      prev_cs = ADC_CS_N;
    end
    if (!seen) tfail("first_fall");

    // data capture, single-cycle valid with ready held high
    wait_load("cap");
    next_word = 16'h0123;
    check("cap_sample", 32'(sample), 32'(L_A5C));
    check("cap_valid", 32'(sample_valid), 32'd1);
    check("cap_cs_high", 32'(ADC_CS_N), 32'd1);
    @(posedge clk_clk); #1;
    check("cap_valid_pulse", 32'(sample_valid), 32'd0);

    // back-pressure across two frames
    sample_ready = 1'b0;
    ovr0 = ovr_seen;
    wait_load("bp1");
    next_word = 16'h0456;
    check("bp1_sample", 32'(sample), 32'(L_123));
    check("bp1_valid", 32'(sample_valid), 32'd1);
    wait_load("bp2");
    next_word = 16'h0789;
    check("bp2_sample", 32'(sample), 32'(L_456));
    check("bp2_valid", 32'(sample_valid), 32'd1);
    repeat (3) begin @(posedge clk_clk); #1; end
    check("bp_ovr_pulses", 32'(ovr_seen - ovr0), 32'd1);
    check("bp_valid_held", 32'(sample_valid), 32'd1);
    sample_ready = 1'b1;
    @(posedge clk_clk); #1;
    check("bp_accept", 32'(sample_valid), 32'd0);

    // load and accept in the same cycle
    sample_ready = 1'b0;
    wait_load("sim1");
    next_word = 16'h0BCD;
    check("sim1_sample", 32'(sample), 32'(L_789));
    wait_bit(15, 1'b1, "sim_edge", ok);
    if (ok) begin
      sample_ready = 1'b1;
      ovr0 = ovr_seen;
      @(posedge clk_clk); #1;
      sample_ready = 1'b0;
      check("sim_valid", 32'(sample_valid), 32'd1);
      check("sim_sample", 32'(sample), 32'(L_BCD));
      check("sim_overrun", 32'(overrun), 32'd0);
      @(posedge clk_clk); #1;
      check("sim_no_ovr", 32'(ovr_seen - ovr0), 32'd0);
    end
    next_word = 16'h0E71;
    sample_ready = 1'b1;
    @(posedge clk_clk); #1;
    sample_ready = 1'b0;

    // enable dropped mid-frame
    wait_bit(7, 1'b0, "en_bit7", ok);
    enable = 1'b0;
    wait_load("en_drop");
    check("en_sample", 32'(sample), 32'(L_E71));
    check("en_valid", 32'(sample_valid), 32'd1);
    cs_low = 0;
    repeat (10 * 2 * HALF + 20) begin
      @(posedge clk_clk); #1;
      if (!ADC_CS_N) cs_low++;
    end
    check("en_cs_parked", 32'(cs_low), 32'd0);

    // reset in the middle of a frame
    enable    = 1'b1;
    next_word = 16'h0AAA;
    wait_bit(9, 1'b0, "rst_bit9", ok);
    reset_n   = 1'b0;
    next_word = 16'h0321;
    @(posedge clk_clk); #1;
    check("rstmid_cs_n", 32'(ADC_CS_N), 32'd1);
    check("rstmid_valid", 32'(sample_valid), 32'd0);
    reset_n      = 1'b1;
    sample_ready = 1'b1;
    wait_load("post_rst");
    check("post_rst_sample", 32'(sample), 32'(L_321));
    check("post_rst_valid", 32'(sample_valid), 32'd1);
    repeat (5) begin @(posedge clk_clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
